roberto_rx_quadro: RTL

// - Downstream of the UART receiver rx_serial_7E1: parses its byte stream into 4-char command frames.
// - Frame format matches the sensor frames we transmit: 3 hex nibbles as ASCII {3'b011,nibble}, then '#' (7'h23).
// - Holds the decoded 12-bit value with a valid/ack handshake for the control FSM.
// - Replaces the ad-hoc 3-register / recv-counter capture in the datapath.

---
 rtl/roberto_rx_quadro_pkg.sv | 16 +
 rtl/contador_m.sv | 18 +
 rtl/roberto_rx_quadro.sv | 67 ++++++
 3 files changed

// File: rtl/roberto_rx_quadro_pkg.sv
// roberto_rx_quadro_pkg: ASCII framing constants and FSM state encoding shared by the command-frame parser.
package roberto_rx_quadro_pkg;
    localparam logic [6:0] ASCII_HASH    = 7'h23;
    localparam logic [2:0] ASCII_PREFIXO = 3'b011;
    typedef enum logic [2:0] {
        INICIAL = 3'd0,
        D1      = 3'd1,
        D2      = 3'd2,
        FIM     = 3'd3,
        VALIDO  = 3'd4,
        ERRO    = 3'd5
    } estado_t;
    function automatic logic eh_nibble(input logic [6:0] c);
        return c[6:4] == ASCII_PREFIXO;
    endfunction
endpackage

// File: rtl/contador_m.sv
// contador_m: modulo-M counter with synchronous clear and enable; fim flags the terminal count M-1.
module contador_m #(
    parameter int M = 100,
    parameter int N = 7
) (
    input  logic clock,
    input  logic reset,
    input  logic zera_s,
    input  logic conta,
    output logic fim
);
    logic [N-1:0] q;
    always_ff @(posedge clock or negedge reset)
        if (!reset) q <= '0;
        else if (zera_s) q <= '0;
        else if (conta) q <= (q == N'(M - 1)) ? '0 : q + 1'b1;
    assign fim = q == N'(M - 1);
endmodule

// File: rtl/roberto_rx_quadro.sv
// roberto_rx_quadro: parses 3 hex nibbles + '#' from rx_serial_7E1 into a 12-bit value with valid/ack handshake.
// Optional ROBERTO_RX_QUADRO_OVERRUN_EN adds a sticky overrun flag for bytes dropped while holding a value.
import roberto_rx_quadro_pkg::*;
module roberto_rx_quadro #(
    parameter int TIMEOUT_CICLOS = 1_000_000,
    parameter int BITS_TIMEOUT   = 20
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [6:0]  rx_dado,
    input  logic        rx_pronto,
    input  logic        ack,
    output logic        cmd_valido,
    output logic [11:0] valor,
    output logic        cmd_erro,
    output logic [2:0]  db_estado
`ifdef ROBERTO_RX_QUADRO_OVERRUN_EN
    ,
    output logic        overrun
`endif
);
    estado_t estado, prox;
    logic [11:0] sh;
    logic fim, timeout, eh_nib, eh_hash;
    assign eh_nib  = eh_nibble(rx_dado);
    assign eh_hash = rx_dado == ASCII_HASH;
    assign timeout = fim & ~rx_pronto;
    contador_m #(.M(TIMEOUT_CICLOS), .N(BITS_TIMEOUT)) u_timeout (
        .clock  (clock),
        .reset  (reset),
        .zera_s (rx_pronto | (estado == INICIAL)),
        .conta  (estado inside {D1, D2, FIM}),
        .fim    (fim)
    );
    always_comb begin
        prox = INICIAL;
        case (estado)
            INICIAL: prox = !rx_pronto ? INICIAL : eh_nib ? D1 : eh_hash ? INICIAL : ERRO;
            D1:      prox = rx_pronto ? (eh_nib ? D2 : ERRO) : timeout ? ERRO : D1;
            D2:      prox = rx_pronto ? (eh_nib ? FIM : ERRO) : timeout ? ERRO : D2;
            FIM:     prox = rx_pronto ? (eh_hash ? VALIDO : ERRO) : timeout ? ERRO : FIM;
            // ack releases the value and the same cycle's byte starts a new frame
            VALIDO:  prox = !ack ? VALIDO : !rx_pronto ? INICIAL : eh_nib ? D1 : eh_hash ? INICIAL : ERRO;
            default: prox = INICIAL;
        endcase
    end
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            estado <= INICIAL;
            sh     <= '0;
            valor  <= '0;
        end else begin
            estado <= prox;
            if (estado == ERRO) sh <= '0;
            else if (rx_pronto && eh_nib && (prox inside {D1, D2, FIM})) sh <= {sh[7:0], rx_dado[3:0]};
            if (estado == FIM && prox == VALIDO) valor <= sh;
        end
    assign cmd_valido = estado == VALIDO;
    assign cmd_erro   = estado == ERRO;
    assign db_estado  = estado;
`ifdef ROBERTO_RX_QUADRO_OVERRUN_EN
    always_ff @(posedge clock or negedge reset)
        if (!reset) overrun <= 1'b0;
        else if (estado == VALIDO && ack) overrun <= 1'b0;
        else if (estado == VALIDO && rx_pronto) overrun <= 1'b1;
`endif
endmodule
